// File: rtl/interp4_fir_pkg.sv
// interp4_fir_pkg: shared sizes, FSM encoding and output saturation for the 4x interpolator
package interp4_fir_pkg;
    localparam int L          = 4;
    localparam int TAPS       = 32;
    localparam int PHASE_TAPS = 8;
    localparam int COEF_W     = 12;
    localparam int ACC_W      = 23;
    localparam int Y_W        = 18;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MAC    = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    function automatic logic signed [Y_W-1:0] sat_y(input logic signed [ACC_W-1:0] v);
        return v > 23'sd131071 ? 18'sd131071 : v < -23'sd131072 ? -18'sd131072 : v[Y_W-1:0];
    endfunction
endpackage

// File: rtl/coeffs32_interp.sv
// coeffs32_interp: 32-tap lowpass prototype ROM; only half is stored since h[n] = h[31-n]
module coeffs32_interp
    import interp4_fir_pkg::*;
(
    input  logic        [4:0]        index,
    output logic signed [COEF_W-1:0] coeff
);
    logic [3:0] half;

    assign half = index[4] ? ~index[3:0] : index[3:0];

    always_comb begin
        case (half)
            4'd0:    coeff = -12'sd3;
            4'd1:    coeff = -12'sd7;
            4'd2:    coeff = -12'sd10;
            4'd3:    coeff = -12'sd7;
            4'd4:    coeff = 12'sd10;
            4'd5:    coeff = 12'sd34;
            4'd6:    coeff = 12'sd48;
            4'd7:    coeff = 12'sd28;
            4'd8:    coeff = -12'sd38;
            4'd9:    coeff = -12'sd122;
            4'd10:   coeff = -12'sd163;
            4'd11:   coeff = -12'sd91;
            4'd12:   coeff = 12'sd127;
            4'd13:   coeff = 12'sd455;
            4'd14:   coeff = 12'sd788;
            default: coeff = 12'sd998;
        endcase
    end
endmodule

// File: rtl/interp4_fir.sv
// interp4_fir: 4x polyphase interpolator; one MAC per cycle fills a back buffer of 4 phases,
// which is swapped with the front buffer that out_tick drains.
module interp4_fir
    import interp4_fir_pkg::*;
#(
    parameter int L    = interp4_fir_pkg::L,
    parameter int TAPS = interp4_fir_pkg::TAPS
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  x_ready,
    input  logic signed [7:0]     x,
    input  logic                  out_tick,
    output logic signed [Y_W-1:0] y,
    output logic                  y_valid,
    output logic                  busy,
    output logic                  underrun,
    output logic                  overrun
);
    logic [1:0]               state;
    logic [2:0]               tap, wp, rptr;
    logic [1:0]               phase;
    logic                     fsel;
    logic signed [7:0]        hist [PHASE_TAPS];
    logic signed [Y_W-1:0]    bufs [2][L];
    logic signed [ACC_W-1:0]  acc, sum;
    logic signed [COEF_W-1:0] coeff;
    logic signed [7:0]        sample;
    logic signed [19:0]       prod;
    logic                     tap_last, phase_last;

    coeffs32_interp rom (.index({tap, phase}), .coeff(coeff));

    // wp already points past the newest sample once MAC starts
    assign sample     = hist[wp - 3'd1 - tap];
    assign prod       = sample * coeff;
    assign sum        = acc + ACC_W'(prod);
    assign tap_last   = tap == 3'(TAPS / L - 1);
    assign phase_last = phase == 2'(L - 1);
    assign busy       = state == S_MAC;

    // rptr[2] set means every front-buffer entry has been consumed
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            tap      <= '0;
            phase    <= '0;
            acc      <= '0;
            wp       <= '0;
            rptr     <= 3'd4;
            fsel     <= 1'b0;
            hist     <= '{default: '0};
            bufs     <= '{default: '0};
            y        <= '0;
            y_valid  <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            y_valid <= out_tick;
            if (out_tick) begin
                if (rptr[2]) underrun <= 1'b1;
                else begin
                    y    <= bufs[fsel][rptr[1:0]];
                    rptr <= rptr + 3'd1;
                end
            end
            if (state == S_COMMIT) begin
                fsel <= ~fsel;
                rptr <= 3'd0;
            end
            if (x_ready) begin
                hist[wp] <= x;
                wp       <= wp + 3'd1;
                tap      <= '0;
                phase    <= '0;
                acc      <= '0;
                state    <= S_MAC;
                if (busy) overrun <= 1'b1;
            end else if (busy) begin
                tap <= tap_last ? 3'd0 : tap + 3'd1;
                acc <= tap_last ? '0 : sum;
                if (tap_last) begin
                    bufs[~fsel][phase] <= sat_y(sum);
                    phase              <= phase + 2'd1;
                    state              <= phase_last ? S_COMMIT : S_MAC;
                end
            end else state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_interp4_fir.sv
// tb_interp4_fir: directed vectors for the 4x interpolator, with a small saturating golden model
module tb_interp4_fir;
    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               x_ready = 1'b0;
    logic signed [7:0]  x = '0;
    logic               out_tick = 1'b0;
    logic signed [17:0] y;
    logic               y_valid, busy, underrun, overrun;

    int checks = 0;
    int errors = 0;
    int hist_m [8];
    int h [32] = '{-3, -7, -10, -7, 10, 34, 48, 28, -38, -122, -163, -91, 127, 455, 788, 998,
                   998, 788, 455, 127, -91, -163, -122, -38, 28, 48, 34, 10, -7, -10, -7, -3};

    typedef struct {
        logic signed [7:0] xin;
        int                e [4];
    } vec_t;
    vec_t imp [8];

    interp4_fir dut (
        .clock(clock), .reset_n(reset_n), .x_ready(x_ready), .x(x), .out_tick(out_tick),
        .y(y), .y_valid(y_valid), .busy(busy), .underrun(underrun), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input int v);
        for (int k = 7; k > 0; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = v;
    endtask

    function automatic int model(input int p);
        int s = 0;
        for (int k = 0; k < 8; k++) s += hist_m[k] * h[4*k + p];
        return s > 131071 ? 131071 : s < -131072 ? -131072 : s;
    endfunction

    task automatic do_reset();
        reset_n  = 1'b0;
        x_ready  = 1'b0;
        out_tick = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) hist_m[k] = 0;
    endtask

    // returns 34 cycles after the x_ready edge, i.e. the first cycle the new block is readable
    task automatic send(input int v);
        x       = 8'(v);
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;
        push(v);
        steps(33);
    endtask

    task automatic rd(input string name, output int v);
        out_tick = 1'b1;
        step();
        out_tick = 1'b0;
        check({name, "_yvalid"}, int'(y_valid), 1);
        v = y;
    endtask

    initial begin
        int v;
        int pos_pat [8] = '{-128, 127, -128, 127, 127, -128, 127, -128};
        int dc_exp [4]  = '{65536, 65472, 65472, 65536};
        int nyq_exp [4] = '{120103, 49341, -50364, -121127};

        imp[0].xin = 127; imp[0].e = '{-381, -889, -1270, -889};
        imp[1].xin = 0;   imp[1].e = '{1270, 4318, 6096, 3556};
        imp[2].xin = 0;   imp[2].e = '{-4826, -15494, -20701, -11557};
        imp[3].xin = 0;   imp[3].e = '{16129, 57785, 100076, 126746};
        imp[4].xin = 0;   imp[4].e = '{126746, 100076, 57785, 16129};
        imp[5].xin = 0;   imp[5].e = '{-11557, -20701, -15494, -4826};
        imp[6].xin = 0;   imp[6].e = '{3556, 6096, 4318, 1270};
        imp[7].xin = 0;   imp[7].e = '{-889, -1270, -889, -381};

        // out_tick held during reset must be ignored
        out_tick = 1'b1;
        steps(2);
        check("rst_y", int'(y), 0);
        check("rst_yvalid", int'(y_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_overrun", int'(overrun), 0);
        reset_n  = 1'b1;
        out_tick = 1'b0;
        for (int k = 0; k < 8; k++) hist_m[k] = 0;

        // latency: busy N+1..N+32, readable at N+34
        x = 8'sd127;
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;
        check("lat_busy_first", int'(busy), 1);
        steps(31);
        check("lat_busy_last", int'(busy), 1);
        step();
        check("lat_busy_commit", int'(busy), 0);
        step();
        rd("lat_rd", v);
        check("lat_y", v, -381);

        // impulse response through the table
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(int'(imp[i].xin));
            for (int p = 0; p < 4; p++) begin
                rd("imp", v);
                check($sformatf("imp%0d_p%0d", i, p), v, imp[i].e[p]);
            end
        end

        // DC then underrun
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send(64);
            for (int p = 0; p < 4; p++) begin
                rd("dc", v);
                check($sformatf("dc%0d_p%0d", i, p), v, i >= 7 ? dc_exp[p] : model(p));
            end
        end
        check("udr_before", int'(underrun), 0);
        rd("udr", v);
        check("udr_hold_y", v, 65536);
        check("udr_flag", int'(underrun), 1);
        send(64);
        check("udr_sticky", int'(underrun), 1);

        // out_tick coinciding with COMMIT reads the old front buffer
        do_reset();
        send(127);
        for (int p = 0; p < 3; p++) rd("coin_pre", v);
        x = 8'sd0;
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;
        steps(32);
        rd("coin", v);
        check("coin_old_front", v, -889);
        rd("coin_next", v);
        check("coin_new_front", v, 1270);
        check("coin_no_udr", int'(underrun), 0);

        // overrun: second sample 10 cycles after the first
        do_reset();
        x = 8'sd100;
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;
        steps(9);
        x = -8'sd50;
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;
        check("ovr_flag", int'(overrun), 1);
        steps(24);
        rd("ovr_nocommit", v);
        check("ovr_nocommit_y", v, 0);
        check("ovr_busy_mid", int'(busy), 1);
        steps(6);
        check("ovr_busy_last", int'(busy), 1);
        step();
        check("ovr_busy_commit", int'(busy), 0);
        step();
        push(100);
        push(-50);
        for (int p = 0; p < 4; p++) begin
            rd("ovr", v);
            check($sformatf("ovr_p%0d", p), v, p == 0 ? 1150 : p == 1 ? 3750 : p == 2 ? 5300 : 3150);
        end

        // reset at MAC tap 20
        do_reset();
        send(127);
        for (int p = 0; p < 5; p++) rd("mid_pre", v);
        x = 8'sd64;
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;
        steps(20);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) hist_m[k] = 0;
        check("mid_y", int'(y), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_underrun", int'(underrun), 0);
        check("mid_yvalid", int'(y_valid), 0);
        steps(20);
        rd("mid_nocommit", v);
        check("mid_nocommit_y", v, 0);
        send(127);
        for (int p = 0; p < 4; p++) begin
            rd("mid_after", v);
            check($sformatf("mid_after_p%0d", p), v, imp[0].e[p]);
        end

        // Nyquist alternation
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(i % 2 == 1 ? -128 : 127);
            if (i >= 8)
                for (int p = 0; p < 4; p++) begin
                    rd("nyq", v);
                    check($sformatf("nyq%0d_p%0d", i, p), v, i == 8 ? nyq_exp[p] : model(p));
                end
        end

        // sign-matched patterns drive phase 0 into both saturation limits
        do_reset();
        for (int i = 0; i < 8; i++) send(pos_pat[i]);
        for (int p = 0; p < 4; p++) begin
            rd("satp", v);
            check($sformatf("satp_p%0d", p), v, p == 0 ? 131071 : model(p));
        end
        for (int i = 0; i < 8; i++) send(pos_pat[i] == 127 ? -128 : 127);
        for (int p = 0; p < 4; p++) begin
            rd("satn", v);
            check($sformatf("satn_p%0d", p), v, p == 0 ? -131072 : model(p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
